// File: rtl/run_sched_pkg.sv
// rtl/run_sched_pkg.sv - shared types and hit codes for the run-detect scheduler
package run_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  typedef enum logic [2:0] {
    D_IDLE = 3'd0,
    ONE1   = 3'd1,
    ONE2   = 3'd2,
    ZERO1  = 3'd3,
    ZERO2  = 3'd4
  } det_state_t;

  localparam logic [1:0] HIT_NONE = 2'b00;
  localparam logic [1:0] HIT_ONE  = 2'b01;
  localparam logic [1:0] HIT_ZERO = 2'b11;

endpackage

// File: rtl/run_det_core.sv
// rtl/run_det_core.sv - serial run-of-three detector, registered state, combinational hit
module run_det_core
  import run_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [1:0] hit
);

  localparam logic [2:0] DS_IDLE  = D_IDLE;
  localparam logic [2:0] DS_ONE1  = ONE1;
  localparam logic [2:0] DS_ONE2  = ONE2;
  localparam logic [2:0] DS_ZERO1 = ZERO1;
  localparam logic [2:0] DS_ZERO2 = ZERO2;

  logic [2:0] det_q;
  logic [2:0] det_d;

  // Next run state; a third-or-later equal bit keeps the detector in ONE2/ZERO2
  always_comb begin
    det_d = det_q;
    hit   = HIT_NONE;
    if (clr) begin
      det_d = DS_IDLE;
    end else if (bit_en) begin
      if (bit_in) begin
        if (det_q == DS_ONE2) hit = HIT_ONE;
        det_d = (det_q == DS_ONE1 || det_q == DS_ONE2) ? DS_ONE2 : DS_ONE1;
      end else begin
        if (det_q == DS_ZERO2) hit = HIT_ZERO;
        det_d = (det_q == DS_ZERO1 || det_q == DS_ZERO2) ? DS_ZERO2 : DS_ZERO1;
      end
    end
  end

  // Run state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) det_q <= DS_IDLE;
    else     det_q <= det_d;
  end

endmodule

// File: rtl/run_detect_scheduler.sv
// rtl/run_detect_scheduler.sv - round-robin sharing of one run detector; RUN_SCHED_LSB_FIRST_EN selects LSB-first shifting
module run_detect_scheduler
  import run_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [$clog2(DATA_W)-1:0] rsp_ones,
  output logic [$clog2(DATA_W)-1:0] rsp_zeros,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int ID_W  = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  logic [1:0]        state_q,   state_d;
  logic [ID_W-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [ID_W-1:0]   id_q,      id_d;
  logic [DATA_W-1:0] shreg_q,   shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  ones_q,    ones_d;
  logic [CNT_W-1:0]  zeros_q,   zeros_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              det_clr;
  logic              det_en;
  logic              det_bit;
  logic [1:0]        det_hit;

  // Round-robin winner: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % N_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Accept strobe only while idle; held low while reset is asserted
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_found && !rst) req_ready[grant_idx] = 1'b1;
  end

`ifdef RUN_SCHED_LSB_FIRST_EN
  assign det_bit = shreg_q[0];
`else
  assign det_bit = shreg_q[DATA_W-1];
`endif

  assign det_clr = (state_q == ST_IDLE) && grant_found;
  assign det_en  = (state_q == ST_SHIFT);

  run_det_core u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (det_clr),
    .bit_en (det_en),
    .bit_in (det_bit),
    .hit    (det_hit)
  );

  // Job sequencing: accept, shift DATA_W bits while counting hits, hold result until taken
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    zeros_d   = zeros_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          shreg_d   = req_data[int'(grant_idx)*DATA_W +: DATA_W];
          id_d      = grant_idx;
          bit_cnt_d = '0;
          ones_d    = '0;
          zeros_d   = '0;
          rr_ptr_d  = (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
`ifdef RUN_SCHED_LSB_FIRST_EN
        shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
`else
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
`endif
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (det_hit == HIT_ONE)  ones_d  = ones_q + CNT_W'(1);
        if (det_hit == HIT_ZERO) zeros_d = zeros_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ones_q    <= '0;
      zeros_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      zeros_q   <= zeros_d;
    end
  end

  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_id    = id_q;
  assign rsp_ones  = ones_q;
  assign rsp_zeros = zeros_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
